// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//
// Oversampling UART receiver. The asynchronous rx line is synchronised, a
// falling edge while idle starts a frame, and every bit is sampled at its
// centre. The receiver takes 7 or 8 data bits LSB-first, then an optional
// even-parity bit, then 1 or 2 stop bits. Each completed frame is presented
// with a one-cycle valid pulse. The payload and the error flags stay stable
// until the next frame completes.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per bit period (>= 4)
//   SYNC_STAGES  : flip-flops in the rx synchroniser (>= 2)
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   rx         : serial input, idle high, asynchronous to clk
//   SW0        : 1 = even parity bit follows the data
//   SW1        : 1 = 8 data bits, 0 = 7 data bits
//   SW2        : 1 = two stop bits, 0 = one stop bit
//   data_out   : last received payload (bit0 = first data bit)
//   valid      : one-cycle pulse when data_out and the flags update
//   parity_err : parity mismatch on the last frame
//   frame_err  : a stop bit was sampled low on the last frame
//   busy       : high from start-bit detection until return to idle
// ---------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       SW0,
    input  logic       SW1,
    input  logic       SW2,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchroniser. The flops reset to 1 (line idle) so that releasing
    // reset can never look like a start bit.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync[0] <= 1'b1;
        end else begin
            r_sync[0] <= rx;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sync[gi] <= 1'b1;
                end else begin
                    r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_rxs = r_sync[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t           r_state, r_state_next;
    logic [CNT_W-1:0] r_cnt, r_cnt_next;
    logic [2:0]       r_idx, r_idx_next;
    logic [7:0]       r_shift, r_shift_next;
    logic             r_cfg_par, r_cfg_par_next;
    logic             r_cfg_8b, r_cfg_8b_next;
    logic             r_cfg_2s, r_cfg_2s_next;
    logic             r_perr, r_perr_next;
    logic             r_ferr, r_ferr_next;
    logic             r_rxs_prev;
    logic [7:0]       r_data_out, r_data_out_next;
    logic             r_valid, r_valid_next;
    logic             r_parity_err, r_parity_err_next;
    logic             r_frame_err, r_frame_err_next;
    logic             r_busy, r_busy_next;

    logic             w_tick;
    logic [2:0]       w_last_idx;
    logic             w_start_edge;

    // End of a full bit period, counted from the previous mid-bit sample.
    assign w_tick       = (r_cnt == CNT_LAST);
    assign w_last_idx   = r_cfg_8b ? 3'd7 : 3'd6;
    // A start needs a genuine 1->0 transition. A line stuck low after a
    // break therefore produces exactly one frame until it goes high again.
    assign w_start_edge = r_rxs_prev & ~w_rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_cfg_par    <= 1'b0;
            r_cfg_8b     <= 1'b1;
            r_cfg_2s     <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_rxs_prev   <= 1'b1;
            r_data_out   <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= r_state_next;
            r_cnt        <= r_cnt_next;
            r_idx        <= r_idx_next;
            r_shift      <= r_shift_next;
            r_cfg_par    <= r_cfg_par_next;
            r_cfg_8b     <= r_cfg_8b_next;
            r_cfg_2s     <= r_cfg_2s_next;
            r_perr       <= r_perr_next;
            r_ferr       <= r_ferr_next;
            r_rxs_prev   <= w_rxs;
            r_data_out   <= r_data_out_next;
            r_valid      <= r_valid_next;
            r_parity_err <= r_parity_err_next;
            r_frame_err  <= r_frame_err_next;
            r_busy       <= r_busy_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        r_state_next      = r_state;
        r_cnt_next        = r_cnt;
        r_idx_next        = r_idx;
        r_shift_next      = r_shift;
        r_cfg_par_next    = r_cfg_par;
        r_cfg_8b_next     = r_cfg_8b;
        r_cfg_2s_next     = r_cfg_2s;
        r_perr_next       = r_perr;
        r_ferr_next       = r_ferr;
        r_data_out_next   = r_data_out;
        r_valid_next      = 1'b0;
        r_parity_err_next = r_parity_err;
        r_frame_err_next  = r_frame_err;

        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    r_state_next   = S_START;
                    r_cnt_next     = '0;
                    // Latch the format so switch changes mid-frame are ignored.
                    r_cfg_par_next = SW0;
                    r_cfg_8b_next  = SW1;
                    r_cfg_2s_next  = SW2;
                    // Cleared here so bit7 stays 0 in 7-bit mode and the parity
                    // flag stays 0 when parity is disabled.
                    r_shift_next   = '0;
                    r_perr_next    = 1'b0;
                    r_ferr_next    = 1'b0;
                end
            end

            S_START: begin
                if (r_cnt == CNT_MID) begin
                    if (w_rxs) begin
                        // Line went back high before mid-bit: treat it as a glitch.
                        r_state_next = S_IDLE;
                    end else begin
                        r_state_next = S_DATA;
                        r_cnt_next   = '0;
                        r_idx_next   = '0;
                    end
                end else begin
                    r_cnt_next = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    r_cnt_next          = '0;
                    r_shift_next[r_idx] = w_rxs;
                    r_idx_next          = r_idx + 1'b1;
                    if (r_idx == w_last_idx) begin
                        r_state_next = r_cfg_par ? S_PARITY : S_STOP1;
                    end
                end else begin
                    r_cnt_next = r_cnt + 1'b1;
                end
            end

            S_PARITY: begin
                if (w_tick) begin
                    r_cnt_next   = '0;
                    // Even parity: the data ones plus the parity bit must be even.
                    r_perr_next  = (^r_shift) ^ w_rxs;
                    r_state_next = S_STOP1;
                end else begin
                    r_cnt_next = r_cnt + 1'b1;
                end
            end

            S_STOP1: begin
                if (w_tick) begin
                    r_cnt_next   = '0;
                    r_ferr_next  = ~w_rxs;
                    r_state_next = r_cfg_2s ? S_STOP2 : S_DONE;
                end else begin
                    r_cnt_next = r_cnt + 1'b1;
                end
            end

            S_STOP2: begin
                if (w_tick) begin
                    r_cnt_next   = '0;
                    r_ferr_next  = r_ferr | ~w_rxs;
                    r_state_next = S_DONE;
                end else begin
                    r_cnt_next = r_cnt + 1'b1;
                end
            end

            S_DONE: begin
                r_state_next      = S_IDLE;
                r_valid_next      = 1'b1;
                r_data_out_next   = r_shift;
                r_parity_err_next = r_perr;
                r_frame_err_next  = r_ferr;
            end

            default: begin
                r_state_next = S_IDLE;
            end
        endcase

        r_busy_next = (r_state_next != S_IDLE);
    end

    assign data_out   = r_data_out;
    assign valid      = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//
// Directed frames are driven onto rx. For each frame the expected payload and
// flags are pushed into a scoreboard queue. A monitor pops one entry per
// valid pulse and compares it. A valid pulse with an empty queue is reported.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       SW0, SW1, SW2;
    logic [7:0] data_out;
    logic       valid, parity_err, frame_err, busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_rx_frame #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .SW0       (SW0),
        .SW1       (SW1),
        .SW2       (SW2),
        .data_out  (data_out),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got frame data 0x%02h, expected no frame", data_out);
            end else begin
                mon_e = sb.pop_front();
                $display("[TB] frame data=0x%02h pe=%0b fe=%0b (exp 0x%02h pe=%0b fe=%0b)",
                         data_out, parity_err, frame_err, mon_e.d, mon_e.pe, mon_e.fe);
                check("data_out", data_out, mon_e.d);
                check("parity_err", {7'b0, parity_err}, {7'b0, mon_e.pe});
                check("frame_err", {7'b0, frame_err}, {7'b0, mon_e.fe});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic bit_wait();
        repeat (CPB) @(negedge clk);
    endtask

    // Drives one frame. rx is left at the last stop-bit level.
    // With toggle_sw1 set, SW1 is inverted during data bit 2 and restored at
    // the first stop bit.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input logic par_bit, input int nstop, input logic stop2,
                              input bit toggle_sw1);
        rx = 1'b0;
        bit_wait();
        check("busy_in_frame", {7'b0, busy}, 8'h01);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            if (toggle_sw1 && i == 2) SW1 = ~SW1;
            bit_wait();
        end
        if (par_en) begin
            rx = par_bit;
            bit_wait();
        end
        rx = 1'b1;
        if (toggle_sw1) SW1 = ~SW1;
        bit_wait();
        if (nstop == 2) begin
            rx = stop2;
            bit_wait();
        end
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        SW0 = 1'b0;
        SW1 = 1'b1;
        SW2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", {7'b0, valid}, 8'h00);
        check("rst_flags", {6'b0, parity_err, frame_err}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // 8N1, 0xA5
        push(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("busy_after_a5", {7'b0, busy}, 8'h00);

        // 7E1, 0x53 (four ones): parity bit 0 is good, 1 is bad
        SW0 = 1'b1;
        SW1 = 1'b0;
        push(8'h53, 1'b0, 1'b0);
        send_frame(8'h53, 7, 1'b1, 1'b0, 1, 1'b1, 1'b0);
        push(8'h53, 1'b1, 1'b0);
        send_frame(8'h53, 7, 1'b1, 1'b1, 1, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // 8N2, 0x3C with the second stop bit low, then the line held low
        SW0 = 1'b0;
        SW1 = 1'b1;
        SW2 = 1'b1;
        push(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        repeat (20 * CPB) @(negedge clk);
        check("busy_during_break", {7'b0, busy}, 8'h00);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Glitch, followed by a clean 8N1 frame carrying 0x0F
        SW2 = 1'b0;
        rx  = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("busy_after_glitch", {7'b0, busy}, 8'h00);
        push(8'h0F, 1'b0, 1'b0);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Back-to-back 0x01, 0xFE, with SW1 toggled during the first frame
        push(8'h01, 1'b0, 1'b0);
        send_frame(8'h01, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        push(8'hFE, 1'b0, 1'b0);
        send_frame(8'hFE, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Reset during data bit 4 of 0x77, then a clean 0x77
        rx = 1'b0;
        bit_wait();
        for (int i = 0; i < 4; i++) begin
            rx = ((8'h77 >> i) & 8'h01) != 0;
            bit_wait();
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_data_out", data_out, 8'h00);
        check("midrst_valid", {7'b0, valid}, 8'h00);
        check("midrst_flags", {6'b0, parity_err, frame_err}, 8'h00);
        check("midrst_busy", {7'b0, busy}, 8'h00);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("busy_after_rst", {7'b0, busy}, 8'h00);
        push(8'h77, 1'b0, 1'b0);
        send_frame(8'h77, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);

        check("scoreboard_empty", 8'(sb.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
UART receiver stage that sits directly downstream of the transmit path and consumes its serial line. It oversamples the line and detects start bits. It samples each bit at mid-period, deserialises 7 or 8 data bits LSB-first, and checks optional even parity and 1 or 2 stop bits. Each frame is presented as a parallel byte with a one-cycle valid pulse and error flags. Frame format is chosen by the same three switches that configure the transmitter, so a looped-back pair agrees on format.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range ≥ 4.
SYNC_STAGES, 2, flip-flops in the rx input synchroniser; legal range ≥ 2.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
rx  input  1  serial line; idle high; asynchronous to clk
SW0  input  1  1 = even parity bit present after data
SW1  input  1  1 = 8 data bits, 0 = 7 data bits
SW2  input  1  1 = two stop bits, 0 = one stop bit
data_out  output  8  last received payload; bit0 = first received data bit; bit7 = 0 in 7-bit mode
valid  output  1  one-cycle pulse when data_out/flags update
parity_err  output  1  parity mismatch on last frame; meaningful with valid
frame_err  output  1  a stop bit sampled low on last frame; meaningful with valid
busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; data_out=0, valid=0, parity_err=0, frame_err=0, busy=0; synchroniser flops preset to 1 so no false start on release.
- rx passes through the SYNC_STAGES synchroniser; all decisions use the synchronised value rxs.
- One bit counter (0..CLKS_PER_BIT-1) and one bit index; widths sized by $clog2.
- IDLE: on rxs falling to 0, go to START, clear the counter, and latch SW0/SW1/SW2 into frame config. Config is frozen for the whole frame, so switch changes mid-frame have no effect. busy=1.
- START: at count = (CLKS_PER_BIT-1)/2 (mid-bit), sample rxs.
  - 1: glitch; return to IDLE with no valid and busy=0.
  - 0: reset the counter and go to DATA with index 0.
- DATA: every CLKS_PER_BIT cycles, sample rxs into shift position index; index++.
  - After 8 bits (SW1=1) or 7 bits (SW1=0) go to PARITY if SW0 else STOP1.
  - In 7-bit mode data_out[7] = 0.
- PARITY: sample one bit; parity_err_next = (XOR of received data bits) XOR sampled bit. Even parity: total ones including the parity bit is even, else error.
- STOP1: sample; frame_err_next = ~sample. Go to STOP2 if SW2 else DONE.
- STOP2: sample; frame_err_next |= ~sample. Go to DONE.
- DONE (1 cycle): update data_out, parity_err (0 if parity disabled), frame_err; valid=1 for exactly this cycle; go to IDLE with busy=0.
- Latency: valid rises 2 clk after the mid-sample of the last stop bit (1 cycle to DONE state, outputs registered), plus synchroniser delay relative to the rx pin.
- A frame with errors still produces valid; data_out holds the received bits.
- data_out and the flags hold until the next valid.
- Framing-error break: if rxs is still 0 on return to IDLE, no new start is detected until rxs returns high. This requires a rising edge, so a stuck-low line yields exactly one frame_err frame.
- Back-to-back frames: a start edge arriving in the cycle right after DONE is detected normally. No idle gap is required beyond the stop bit(s).
- rst asserted mid-frame: immediate return to reset values; a partial frame is discarded and never signalled.

Test Plan:
- 8N1 (SW0=0, SW1=1, SW2=0), send 0xA5 LSB-first with CLKS_PER_BIT=16 -> one valid pulse, data_out=0xA5, parity_err=0, frame_err=0; busy high ≈10 bit periods.
- 7E1 (SW0=1, SW1=0), send payload 0x53 with parity bit 0 (four ones) -> data_out=0x53, parity_err=0. Repeat with parity bit 1 -> parity_err=1, valid still pulses.
- 8N2 (SW2=1), send 0x3C with second stop bit driven 0 -> data_out=0x3C, frame_err=1. Then hold rx=0 -> no further valid until rx returns high.
- Glitch: rx low for CLKS_PER_BIT/4 cycles then high -> no valid, busy returns 0, next clean 0x0F frame received correctly.
- Back-to-back 0x01, 0xFE with no idle gap, and SW1 toggled during the first frame -> two valid pulses, values 0x01 then 0xFE. The first frame is decoded with the config latched at its start.
- Assert rst during data bit 4 of a frame, release, then send 0x77 -> all outputs 0 during reset, no valid for the aborted frame, 0x77 received correctly.
